// File: rtl/wave_recorder.sv
`timescale 1ns / 1ps
// -----------------------------------------------------------------------------
// wave_recorder
//
// Captures audio samples from a left-justified codec ADC serial stream and
// writes them, one 16-bit word per frame, into one of four wave slots of a
// dual-port RAM through dpram_ctrl (wr strobe out, done pulse back).
//
// Ports
//   clk_50    in   system clock, rising edge
//   daclrck   in   asynchronous active-high reset
//   bclk      in   codec bit clock (asynchronous to clk_50)
//   adclrck   in   codec LR clock, high = left-channel frame
//   adcdat    in   codec serial data, MSB first, left-justified
//   rec_en    in   level-sensitive record request
//   wave_sel  in   target slot, latched when recording starts
//   done      in   one-cycle write-complete pulse from dpram_ctrl
//   addr      out  RAM address {slot, pos}
//   din       out  RAM write data, byte-swapped sample
//   wr        out  one-cycle write strobe
//   busy      out  high outside IDLE and FULL
//   full      out  slot completely written
//   overrun   out  sticky, a frame arrived while a write was pending
//
// Build option
//   REC_MONO_MIX_EN  when defined, the left and right words of each frame are
//                    captured and the signed average (L+R)>>>1 is written;
//                    otherwise only the left word is captured.
// -----------------------------------------------------------------------------
module wave_recorder #(
  parameter int POS_W    = 13,
  parameter int SAMPLE_W = 16
) (
  input  logic                  clk_50,
  input  logic                  daclrck,
  input  logic                  bclk,
  input  logic                  adclrck,
  input  logic                  adcdat,
  input  logic                  rec_en,
  input  logic [1:0]            wave_sel,
  input  logic                  done,
  output logic [POS_W+1:0]      addr,
  output logic [SAMPLE_W-1:0]   din,
  output logic                  wr,
  output logic                  busy,
  output logic                  full,
  output logic                  overrun
);

  localparam int CNT_W = $clog2(SAMPLE_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SAMPLE_W - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ARM       = 3'd1,
    SHIFT     = 3'd2,
    WRITE     = 3'd3,
    WAIT_DONE = 3'd4,
    FULL      = 3'd5
  } state_t;

  state_t state_q, state_d;

  // Synchronisers; the third bclk/adclrck stage is only the edge-detect history
  logic bclk_s1_q, bclk_s2_q, bclk_s3_q;
  logic lrck_s1_q, lrck_s2_q, lrck_s3_q;
  logic dat_s1_q, dat_s2_q;
  logic bclk_rise, lrck_rise;

  logic [SAMPLE_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]    bitcnt_q, bitcnt_d;
  logic [POS_W-1:0]    pos_q, pos_d;
  logic [1:0]          slot_q, slot_d;
  logic [POS_W+1:0]    addr_q, addr_d;
  logic [SAMPLE_W-1:0] din_q, din_d;
  logic                ovr_q, ovr_d;
  logic [SAMPLE_W-1:0] new_word;
  logic                word_done;

`ifdef REC_MONO_MIX_EN
  localparam logic [1:0] PH_LEFT  = 2'd0;
  localparam logic [1:0] PH_GAP   = 2'd1;
  localparam logic [1:0] PH_RIGHT = 2'd2;
  logic [1:0]          phase_q, phase_d;
  logic [SAMPLE_W-1:0] left_q, left_d;
  logic                lrck_fall;

  // Signed average in SAMPLE_W+1 bits so L+R cannot overflow, then truncated
  function automatic logic [SAMPLE_W-1:0] mix_avg(input logic signed [SAMPLE_W-1:0] l,
                                                  input logic signed [SAMPLE_W-1:0] r);
    logic signed [SAMPLE_W:0] sum;
    sum = {l[SAMPLE_W-1], l} + {r[SAMPLE_W-1], r};
    return SAMPLE_W'(sum >>> 1);
  endfunction
`endif

  // RAM expects little-endian words
  function automatic logic [SAMPLE_W-1:0] byte_swap(input logic [SAMPLE_W-1:0] s);
    return {s[SAMPLE_W/2-1:0], s[SAMPLE_W-1:SAMPLE_W/2]};
  endfunction

  // ---- stage: codec input synchronisation ----
  always_ff @(posedge clk_50 or posedge daclrck) begin
    if (daclrck) begin
      bclk_s1_q <= 1'b0;
      bclk_s2_q <= 1'b0;
      bclk_s3_q <= 1'b0;
      lrck_s1_q <= 1'b0;
      lrck_s2_q <= 1'b0;
      lrck_s3_q <= 1'b0;
      dat_s1_q  <= 1'b0;
      dat_s2_q  <= 1'b0;
    end else begin
      bclk_s1_q <= bclk;
      bclk_s2_q <= bclk_s1_q;
      bclk_s3_q <= bclk_s2_q;
      lrck_s1_q <= adclrck;
      lrck_s2_q <= lrck_s1_q;
      lrck_s3_q <= lrck_s2_q;
      dat_s1_q  <= adcdat;
      dat_s2_q  <= dat_s1_q;
    end
  end

  assign bclk_rise = bclk_s2_q & ~bclk_s3_q;
  assign lrck_rise = lrck_s2_q & ~lrck_s3_q;
`ifdef REC_MONO_MIX_EN
  assign lrck_fall = ~lrck_s2_q & lrck_s3_q;
`endif

  // adcdat shares the bclk synchroniser depth, so dat_s2_q is the bit that
  // belongs to the bclk edge seen this cycle
  assign new_word = SAMPLE_W'({shift_q, dat_s2_q});

`ifdef REC_MONO_MIX_EN
  assign word_done = (state_q == SHIFT) && bclk_rise && (bitcnt_q == LAST_BIT) &&
                     (phase_q == PH_RIGHT);
`else
  assign word_done = (state_q == SHIFT) && bclk_rise && (bitcnt_q == LAST_BIT);
`endif

  // ---- stage: FSM state register ----
  always_ff @(posedge clk_50 or posedge daclrck) begin
    if (daclrck) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (rec_en) state_d = ARM;
      ARM: begin
        if (!rec_en)        state_d = IDLE;
        else if (lrck_rise) state_d = SHIFT;
      end
      SHIFT: begin
        if (!rec_en)        state_d = IDLE;
        else if (word_done) state_d = WRITE;
      end
      WRITE:     state_d = WAIT_DONE;
      WAIT_DONE: begin
        if (done) begin
          if (pos_q == '1)  state_d = FULL;
          else if (rec_en)  state_d = ARM;
          else              state_d = IDLE;
        end
      end
      FULL:      if (!rec_en) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    wr   = (state_q == WRITE);
    busy = (state_q != IDLE) && (state_q != FULL);
    full = (state_q == FULL);
  end

  // Datapath next state
  always_comb begin
    shift_d  = shift_q;
    bitcnt_d = bitcnt_q;
    pos_d    = pos_q;
    slot_d   = slot_q;
    addr_d   = addr_q;
    din_d    = din_q;
    ovr_d    = ovr_q;
`ifdef REC_MONO_MIX_EN
    phase_d  = phase_q;
    left_d   = left_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (rec_en) begin
          slot_d = wave_sel;
          pos_d  = '0;
          ovr_d  = 1'b0;
        end
      end
      ARM: begin
        if (rec_en && lrck_rise) begin
          bitcnt_d = '0;
`ifdef REC_MONO_MIX_EN
          phase_d  = PH_LEFT;
`endif
        end
      end
      SHIFT: begin
        if (rec_en) begin
`ifdef REC_MONO_MIX_EN
          // Bits between the end of the left word and the LR fall are padding
          if (phase_q == PH_GAP) begin
            if (lrck_fall) begin
              bitcnt_d = '0;
              phase_d  = PH_RIGHT;
            end
          end else if (bclk_rise) begin
            shift_d  = new_word;
            bitcnt_d = bitcnt_q + CNT_W'(1);
            if ((bitcnt_q == LAST_BIT) && (phase_q == PH_LEFT)) begin
              left_d  = new_word;
              phase_d = PH_GAP;
            end
          end
          if (word_done) begin
            addr_d = {slot_q, pos_q};
            din_d  = byte_swap(mix_avg(left_q, new_word));
          end
`else
          if (bclk_rise) begin
            shift_d  = new_word;
            bitcnt_d = bitcnt_q + CNT_W'(1);
          end
          if (word_done) begin
            addr_d = {slot_q, pos_q};
            din_d  = byte_swap(new_word);
          end
`endif
        end
      end
      WRITE: begin
        if (lrck_rise) ovr_d = 1'b1;
      end
      WAIT_DONE: begin
        // A frame starting while the write is pending is dropped, not queued
        if (lrck_rise) ovr_d = 1'b1;
        if (done)      pos_d = pos_q + POS_W'(1);
      end
      default: ;
    endcase
  end

  // ---- stage: datapath registers ----
  always_ff @(posedge clk_50 or posedge daclrck) begin
    if (daclrck) begin
      shift_q  <= '0;
      bitcnt_q <= '0;
      pos_q    <= '0;
      slot_q   <= '0;
      addr_q   <= '0;
      din_q    <= '0;
      ovr_q    <= 1'b0;
`ifdef REC_MONO_MIX_EN
      phase_q  <= PH_LEFT;
      left_q   <= '0;
`endif
    end else begin
      shift_q  <= shift_d;
      bitcnt_q <= bitcnt_d;
      pos_q    <= pos_d;
      slot_q   <= slot_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
      ovr_q    <= ovr_d;
`ifdef REC_MONO_MIX_EN
      phase_q  <= phase_d;
      left_q   <= left_d;
`endif
    end
  end

  assign addr    = addr_q;
  assign din     = din_q;
  assign overrun = ovr_q;

endmodule

// File: tb/tb_wave_recorder.sv
`timescale 1ns / 1ps
// Directed bench for wave_recorder. Instance a uses the default geometry;
// instance b has a 16-entry slot so a whole slot can be filled quickly.
module tb_wave_recorder;

  logic        clk_50 = 1'b0;
  logic        daclrck = 1'b1;
  logic        bclk = 1'b0;
  logic        adclrck = 1'b0;
  logic        adcdat = 1'b0;
  logic        rec_en = 1'b0;
  logic [1:0]  wave_sel = 2'd0;

  logic        done_a = 1'b0;
  logic [14:0] addr_a;
  logic [15:0] din_a;
  logic        wr_a, busy_a, full_a, ovr_a;

  logic        done_b = 1'b0;
  logic [5:0]  addr_b;
  logic [15:0] din_b;
  logic        wr_b, busy_b, full_b, ovr_b;

  always #10 clk_50 = ~clk_50;

  wave_recorder dut_a (
    .clk_50(clk_50), .daclrck(daclrck), .bclk(bclk), .adclrck(adclrck),
    .adcdat(adcdat), .rec_en(rec_en), .wave_sel(wave_sel), .done(done_a),
    .addr(addr_a), .din(din_a), .wr(wr_a), .busy(busy_a), .full(full_a),
    .overrun(ovr_a)
  );

  wave_recorder #(.POS_W(4)) dut_b (
    .clk_50(clk_50), .daclrck(daclrck), .bclk(bclk), .adclrck(adclrck),
    .adcdat(adcdat), .rec_en(rec_en), .wave_sel(wave_sel), .done(done_b),
    .addr(addr_b), .din(din_b), .wr(wr_b), .busy(busy_b), .full(full_b),
    .overrun(ovr_b)
  );

  // dpram_ctrl stand-ins: count writes, remember the last one, and answer
  // with done one cycle later (instance a can have done withheld)
  logic        hold_a = 1'b0;
  logic        pend_a = 1'b0;
  int          wr_cnt_a = 0;
  logic [14:0] last_addr_a = '0;
  logic [15:0] last_din_a = '0;

  always @(posedge clk_50) begin
    done_a <= 1'b0;
    if (wr_a) begin
      wr_cnt_a    <= wr_cnt_a + 1;
      last_addr_a <= addr_a;
      last_din_a  <= din_a;
      pend_a      <= 1'b1;
    end else if (pend_a && !hold_a) begin
      done_a <= 1'b1;
      pend_a <= 1'b0;
    end
  end

  logic        pend_b = 1'b0;
  int          wr_cnt_b = 0;
  logic [5:0]  last_addr_b = '0;
  logic [15:0] last_din_b = '0;

  always @(posedge clk_50) begin
    done_b <= 1'b0;
    if (wr_b) begin
      wr_cnt_b    <= wr_cnt_b + 1;
      last_addr_b <= addr_b;
      last_din_b  <= din_b;
      pend_b      <= 1'b1;
    end else if (pend_b) begin
      done_b <= 1'b1;
      pend_b <= 1'b0;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected RAM word for a frame with left word l and right word r
  function automatic logic [15:0] exp_din(input logic [15:0] l, input logic [15:0] r);
    logic [15:0] s;
`ifdef REC_MONO_MIX_EN
    s = 16'(({l[15], l} + {r[15], r}) >> 1);
`else
    s = l;
    if (r == 16'hFFFF) s = l;
`endif
    return {s[7:0], s[15:8]};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk_50);
  endtask

  task automatic bit_out(input logic b);
    bclk = 1'b0;
    adcdat = b;
    @(negedge clk_50);
    bclk = 1'b1;
    @(negedge clk_50);
  endtask

  // One codec frame; abort_at >= 0 drops rec_en after that many left bits
  task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input int abort_at);
    bclk = 1'b0;
    adcdat = 1'b0;
    adclrck = 1'b1;
    @(negedge clk_50);
    for (int i = 15; i >= 0; i--) begin
      if ((15 - i) == abort_at) rec_en = 1'b0;
      bit_out(l[i]);
    end
    bclk = 1'b0;
    adcdat = 1'b0;
    adclrck = 1'b0;
    @(negedge clk_50);
    for (int i = 15; i >= 0; i--) bit_out(r[i]);
    bclk = 1'b0;
    adcdat = 1'b0;
    tick(10);
  endtask

  int base_a;
  int base_b;

  initial begin
    // Reset state
    tick(3);
    check("rst_addr", 32'(addr_a), 32'h0);
    check("rst_din", 32'(din_a), 32'h0);
    check("rst_wr", 32'(wr_a), 32'h0);
    check("rst_busy", 32'(busy_a), 32'h0);
    check("rst_full", 32'(full_a), 32'h0);
    check("rst_ovr", 32'(ovr_a), 32'h0);
    daclrck = 1'b0;
    tick(3);
    check("idle_busy", 32'(busy_a), 32'h0);

    // First frame into slot 2
    wave_sel = 2'd2;
    rec_en = 1'b1;
    tick(2);
    check("arm_busy", 32'(busy_a), 32'h1);
    send_frame(16'h1234, 16'h0000, -1);
    check("f1_wrcnt", 32'(wr_cnt_a), 32'd1);
    check("f1_addr", 32'(last_addr_a), 32'h4000);
    check("f1_din", 32'(last_din_a), 32'(exp_din(16'h1234, 16'h0000)));
    check("f1_addr_hold", 32'(addr_a), 32'h4000);
    check("f1_din_hold", 32'(din_a), 32'(exp_din(16'h1234, 16'h0000)));
    check("f1_busy", 32'(busy_a), 32'h1);

    // wave_sel changes mid-recording are ignored; right word ignored unless mixing
    wave_sel = 2'd1;
    send_frame(16'h00FF, 16'hFFFF, -1);
    check("f2_wrcnt", 32'(wr_cnt_a), 32'd2);
    check("f2_addr", 32'(last_addr_a), 32'h4001);
    check("f2_din", 32'(last_din_a), 32'(exp_din(16'h00FF, 16'hFFFF)));

    // Overrun: done withheld across the next frame
    hold_a = 1'b1;
    send_frame(16'hABCD, 16'h0000, -1);
    check("ov_wrcnt0", 32'(wr_cnt_a), 32'd3);
    check("ov_addr0", 32'(addr_a), 32'h4002);
    check("ov_flag0", 32'(ovr_a), 32'h0);
    send_frame(16'h1111, 16'h0000, -1);
    check("ov_flag1", 32'(ovr_a), 32'h1);
    check("ov_wrcnt1", 32'(wr_cnt_a), 32'd3);
    check("ov_addr1", 32'(addr_a), 32'h4002);
    hold_a = 1'b0;
    tick(3);
    send_frame(16'h5555, 16'h0000, -1);
    check("ov_wrcnt2", 32'(wr_cnt_a), 32'd4);
    check("ov_addr2", 32'(last_addr_a), 32'h4003);
    check("ov_din2", 32'(last_din_a), 32'(exp_din(16'h5555, 16'h0000)));
    check("ov_sticky", 32'(ovr_a), 32'h1);

    // rec_en dropped in ARM, then restart clears overrun
    rec_en = 1'b0;
    tick(3);
    check("drop_arm_busy", 32'(busy_a), 32'h0);
    wave_sel = 2'd3;
    rec_en = 1'b1;
    tick(2);
    check("restart_ovr", 32'(ovr_a), 32'h0);

    // rec_en dropped during bit 8 of SHIFT
    send_frame(16'hFFFF, 16'h0000, 8);
    check("abort_wrcnt", 32'(wr_cnt_a), 32'd4);
    check("abort_busy", 32'(busy_a), 32'h0);
    check("abort_addr_hold", 32'(addr_a), 32'h4003);
    rec_en = 1'b1;
    tick(2);
    send_frame(16'h0F0F, 16'h0000, -1);
    check("abort_next_addr", 32'(last_addr_a), 32'h6000);
    check("abort_next_wrcnt", 32'(wr_cnt_a), 32'd5);

    // Fill a whole slot of the small instance
    rec_en = 1'b0;
    tick(3);
    wave_sel = 2'd1;
    rec_en = 1'b1;
    tick(2);
    base_a = wr_cnt_a;
    base_b = wr_cnt_b;
    for (int k = 0; k < 16; k++) send_frame(16'(16'h0100 + k), 16'h0000, -1);
    check("fill_b_wrcnt", 32'(wr_cnt_b - base_b), 32'd16);
    check("fill_b_last_addr", 32'(last_addr_b), 32'h1F);
    check("fill_b_last_din", 32'(last_din_b), 32'(exp_din(16'h010F, 16'h0000)));
    check("fill_b_full", 32'(full_b), 32'h1);
    check("fill_b_busy", 32'(busy_b), 32'h0);
    check("fill_b_ovr", 32'(ovr_b), 32'h0);
    send_frame(16'h0200, 16'h0000, -1);
    check("fill_b_no_more_wr", 32'(wr_cnt_b - base_b), 32'd16);
    check("fill_b_full_hold", 32'(full_b), 32'h1);
    check("fill_a_wrcnt", 32'(wr_cnt_a - base_a), 32'd17);
    check("fill_a_last_addr", 32'(last_addr_a), 32'h2010);
    check("fill_a_not_full", 32'(full_a), 32'h0);
    rec_en = 1'b0;
    tick(3);
    check("full_release", 32'(full_b), 32'h0);
    check("full_release_busy", 32'(busy_b), 32'h0);

    // Reset while waiting for done, then a late done in IDLE
    wave_sel = 2'd2;
    rec_en = 1'b1;
    tick(2);
    hold_a = 1'b1;
    base_a = wr_cnt_a;
    send_frame(16'h2222, 16'h0000, -1);
    check("rst_pre_wr", 32'(wr_cnt_a - base_a), 32'd1);
    check("rst_pre_busy", 32'(busy_a), 32'h1);
    daclrck = 1'b1;
    #1;
    check("rst_async_addr", 32'(addr_a), 32'h0);
    check("rst_async_busy", 32'(busy_a), 32'h0);
    rec_en = 1'b0;
    tick(2);
    daclrck = 1'b0;
    tick(1);
    hold_a = 1'b0;
    tick(5);
    check("late_done_busy", 32'(busy_a), 32'h0);
    check("late_done_addr", 32'(addr_a), 32'h0);
    check("late_done_din", 32'(din_a), 32'h0);
    check("late_done_ovr", 32'(ovr_a), 32'h0);
    check("late_done_full", 32'(full_a), 32'h0);
    check("late_done_wr", 32'(wr_cnt_a - base_a), 32'd1);
    rec_en = 1'b1;
    tick(2);
    send_frame(16'h3333, 16'h0000, -1);
    check("post_rst_addr", 32'(last_addr_a), 32'h4000);

    // Mix corner values (left word only in the default build)
    rec_en = 1'b0;
    tick(3);
    wave_sel = 2'd0;
    rec_en = 1'b1;
    tick(2);
    send_frame(16'h7FFF, 16'h0001, -1);
    check("mix1_addr", 32'(last_addr_a), 32'h0000);
`ifdef REC_MONO_MIX_EN
    check("mix1_din", 32'(last_din_a), 32'h0040);
`else
    check("mix1_din", 32'(last_din_a), 32'hFF7F);
`endif
    send_frame(16'h8000, 16'h8000, -1);
    check("mix2_addr", 32'(last_addr_a), 32'h0001);
    check("mix2_din", 32'(last_din_a), 32'h0080);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
